ripple_count_sampler: RTL and testbench
=======================================

Name: ripple_count_sampler

Overview:
- Downstream consumer of the ripple counters.
- Ripple counter outputs settle bit-by-bit after each clock edge, so a single sample can be torn (mid-ripple). This block synchronises the counter bus into the clk domain and accepts a value only after it has been stable for STABLE consecutive cycles.
- It publishes the accepted value with a one-cycle valid pulse and extends the count by tracking wrap-arounds.

Parameters:
- N, 4, width of counter bus being sampled.
- STABLE, 2, consecutive identical synchronised samples required to accept (>=1).
- MAX_TRY, 8, compare cycles allowed before declaring a stability error (> STABLE).
- EXT, 8, width of wrap counter (count extension).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state.
- cnt_in  input  N  ripple counter output, treated as asynchronous.
- sample_req  input  1  request one stable sample; level sampled at rising edge.
- busy  output  1  high while a sample is in progress (state COMPARE).
- valid  output  1  one-cycle pulse: cnt_out/wrap_cnt just updated.
- cnt_out  output  N  last accepted counter value.
- wrap  output  1  one-cycle pulse coincident with valid when a wrap was detected.
- wrap_cnt  output  EXT  number of wraps detected since reset, modulo 2^EXT.
- err  output  1  one-cycle pulse: no stable value within MAX_TRY cycles.

Behaviour:
- Reset values: all outputs 0; synchroniser flops 0; state IDLE; internal prev/last/match/tries 0.
- Synchroniser: 2-flop per bit on cnt_in → s2. A change on cnt_in reaches s2 after 2 edges. No Gray assumption; tearing is handled by the stability check.
- State IDLE (busy=0):
  - sample_req=1 at edge → COMPARE; last<=s2, match<=0, tries<=0.
- State COMPARE (busy=1), at each edge:
  - tries<=tries+1.
  - If s2==last: match<=match+1. Else: last<=s2, match<=0.
  - Accept when the match increment reaches STABLE:
    - cnt_out<=last; valid<=1; state<=IDLE.
    - If last < cnt_out (unsigned, pre-update value): wrap<=1 and wrap_cnt<=wrap_cnt+1. Equal or greater: no wrap.
  - Else if tries+1==MAX_TRY: err<=1; state<=IDLE; cnt_out, wrap_cnt unchanged.
  - Accept has priority over err on the same edge.
- Latency: with s2 already steady, req seen at edge k gives valid high in the cycle after edge k+STABLE.
- valid, wrap and err are single-cycle registered pulses, deasserted on the following edge.
- sample_req while busy is ignored (not queued).
- sample_req high in the cycle valid/err is high: state is IDLE, so it is accepted as a new request (back-to-back supported).
- Holding sample_req high continuously gives repeated samples, one per STABLE+1 cycles minimum.
- wrap_cnt rolls from 2^EXT-1 to 0 silently; wrap still pulses.
- The first accepted value after reset is compared against cnt_out=0, so it never flags a wrap.
- Reset asserted mid-COMPARE: immediate return to IDLE with all outputs 0; no valid or err is issued for the aborted request.

Test Plan:
- cnt_in held at 5, reset released, wait 3 cycles, pulse sample_req → busy for 2 cycles, valid pulse, cnt_out=5, wrap=0, wrap_cnt=0.
- Accept 14, then change cnt_in to 2, wait, sample → valid with cnt_out=2, wrap=1, wrap_cnt=1. A following sample of 2 gives wrap=0.
- cnt_in toggling every cycle between 0 and 15 (MAX_TRY=8) → no valid; err pulses exactly 8 edges after the request edge; cnt_out keeps its prior value.
- cnt_in changes once mid-COMPARE (3→4) → match restarts; valid arrives later with cnt_out=4, never 3 or a torn value.
- Assert reset two cycles into COMPARE → busy=0, cnt_out=0, wrap_cnt=0 immediately. After release, no valid/err until a new sample_req.
- Preload 255 wraps (EXT=8), force one more wrap → wrap=1, wrap_cnt=0. sample_req pulsed while busy → exactly one valid produced.

Source files
------------

// File: rtl/ripple_count_sampler.sv
// ripple_count_sampler
// Samples an asynchronous ripple-counter bus into the clk domain. A value is
// accepted only once the synchronised bus has held the same value for STABLE
// consecutive compares, so a reading taken while the counter bits are still
// settling is never published. Accepted values are published with a one-cycle
// valid pulse. The block also counts how many times the counter has wrapped.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset, clears all state
//   cnt_in     ripple counter bus (asynchronous to clk)
//   sample_req request one stable sample (level, sampled at rising edge)
//   busy       high while a sample is in progress
//   valid      one-cycle pulse, cnt_out/wrap_cnt just updated
//   cnt_out    last accepted counter value
//   wrap       one-cycle pulse with valid when a wrap-around was seen
//   wrap_cnt   wraps seen since reset, modulo 2^EXT
//   err        one-cycle pulse, no stable value within MAX_TRY compares
//
// state   | meaning
// IDLE    | waiting for sample_req
// COMPARE | checking synchronised bus for STABLE consecutive matches

module ripple_count_sampler #(
  parameter int N       = 4,
  parameter int STABLE  = 2,
  parameter int MAX_TRY = 8,
  parameter int EXT     = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   cnt_in,
  input  logic           sample_req,
  output logic           busy,
  output logic           valid,
  output logic [N-1:0]   cnt_out,
  output logic           wrap,
  output logic [EXT-1:0] wrap_cnt,
  output logic           err
);

  localparam int MW = $clog2(STABLE + 1);
  localparam int TW = $clog2(MAX_TRY + 1);

  typedef enum logic {
    IDLE    = 1'b0,
    COMPARE = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   sync1_q, s2_q;
  logic [N-1:0]   last_q, last_d;
  logic [MW-1:0]  match_q, match_d, match_inc;
  logic [TW-1:0]  tries_q, tries_d, tries_inc;
  logic [N-1:0]   cnt_out_q, cnt_out_d;
  logic [EXT-1:0] wrap_cnt_q, wrap_cnt_d;
  logic           valid_q, valid_d;
  logic           wrap_q, wrap_d;
  logic           err_q, err_d;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    match_d    = match_q;
    tries_d    = tries_q;
    cnt_out_d  = cnt_out_q;
    wrap_cnt_d = wrap_cnt_q;
    valid_d    = 1'b0;
    wrap_d     = 1'b0;
    err_d      = 1'b0;
    match_inc  = match_q + MW'(1);
    tries_inc  = tries_q + TW'(1);

    case (state_q)
      IDLE: begin
        if (sample_req) begin
          state_d = COMPARE;
          last_d  = s2_q;
          match_d = '0;
          tries_d = '0;
        end
      end
      COMPARE: begin
        tries_d = tries_inc;
        if (s2_q == last_q) begin
          match_d = match_inc;
        end else begin
          // Any difference restarts the stability run from the new value.
          last_d  = s2_q;
          match_d = '0;
        end
        // Accept wins over the try limit when both land on the same edge.
        if ((s2_q == last_q) && (match_inc == MW'(STABLE))) begin
          cnt_out_d = last_q;
          valid_d   = 1'b1;
          state_d   = IDLE;
          // A smaller value than the previous accept means the counter rolled over.
          if (last_q < cnt_out_q) begin
            wrap_d     = 1'b1;
            wrap_cnt_d = wrap_cnt_q + EXT'(1);
          end
        end else if (tries_inc == TW'(MAX_TRY)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sync1_q    <= '0;
      s2_q       <= '0;
      last_q     <= '0;
      match_q    <= '0;
      tries_q    <= '0;
      cnt_out_q  <= '0;
      wrap_cnt_q <= '0;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= cnt_in;
      s2_q       <= sync1_q;
      last_q     <= last_d;
      match_q    <= match_d;
      tries_q    <= tries_d;
      cnt_out_q  <= cnt_out_d;
      wrap_cnt_q <= wrap_cnt_d;
      valid_q    <= valid_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
    end
  end

  assign busy     = (state_q == COMPARE);
  assign valid    = valid_q;
  assign cnt_out  = cnt_out_q;
  assign wrap     = wrap_q;
  assign wrap_cnt = wrap_cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Bench for ripple_count_sampler. The reference model keeps the history of
// cnt_in per clock edge. For a request, it looks for the first edge where the
// last STABLE+1 synchronised samples (the request edge included) are all equal.
module tb_ripple_count_sampler;
  localparam int N       = 4;
  localparam int STABLE  = 2;
  localparam int MAX_TRY = 8;
  localparam int EXT     = 8;
  localparam int HMAX    = 16384;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   cnt_in;
  logic           sample_req;
  logic           busy, valid, wrap, err;
  logic [N-1:0]   cnt_out;
  logic [EXT-1:0] wrap_cnt;

  ripple_count_sampler #(.N(N), .STABLE(STABLE), .MAX_TRY(MAX_TRY), .EXT(EXT)) dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_in     (cnt_in),
    .sample_req (sample_req),
    .busy       (busy),
    .valid      (valid),
    .cnt_out    (cnt_out),
    .wrap       (wrap),
    .wrap_cnt   (wrap_cnt),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] hist [HMAX];
  int edge_n  = 0;
  int rel_edge = 0;

  bit             m_busy;
  int             m_req_edge;
  logic [N-1:0]   m_cnt;
  logic [EXT-1:0] m_wcnt;
  bit             m_valid, m_wrap, m_err;

  int obs_valid, obs_wrap, obs_err, obs_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value the sampler compares at edge e: cnt_in as driven two edges earlier,
  // or 0 if that was before the last reset release.
  function automatic logic [N-1:0] s2_at(input int e);
    if (e - 2 < rel_edge) return '0;
    return hist[e - 2];
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_req_edge = 0; m_cnt = '0; m_wcnt = '0;
    m_valid = 0; m_wrap = 0; m_err = 0;
  endfunction

  function automatic void model_edge(input int e, input logic req);
    m_valid = 0; m_wrap = 0; m_err = 0;
    if (m_busy) begin
      int j;
      logic [N-1:0] vj;
      bit run;
      j   = e - m_req_edge;
      vj  = s2_at(e);
      run = (j >= STABLE);
      for (int i = 1; i <= STABLE; i++)
        if (s2_at(e - i) != vj) run = 0;
      if (run) begin
        m_valid = 1;
        if (vj < m_cnt) begin
          m_wrap = 1;
          m_wcnt = m_wcnt + 1'b1;
        end
        m_cnt  = vj;
        m_busy = 0;
      end else if (j == MAX_TRY) begin
        m_err  = 1;
        m_busy = 0;
      end
    end else if (req) begin
      m_busy     = 1;
      m_req_edge = e;
    end
  endfunction

  task automatic check_outputs();
    chk("busy",     busy,     m_busy);
    chk("valid",    valid,    m_valid);
    chk("wrap",     wrap,     m_wrap);
    chk("err",      err,      m_err);
    chk("cnt_out",  cnt_out,  m_cnt);
    chk("wrap_cnt", wrap_cnt, m_wcnt);
  endtask

  task automatic step(input logic req, input logic [N-1:0] val);
    @(negedge clk);
    sample_req = req;
    cnt_in     = val;
    hist[edge_n] = val;
    @(posedge clk);
    model_edge(edge_n, req);
    edge_n++;
    #1;
    if (valid === 1'b1) obs_valid++;
    if (wrap === 1'b1)  obs_wrap++;
    if (err === 1'b1)   obs_err++;
    if (busy === 1'b1)  obs_busy++;
    check_outputs();
  endtask

  task automatic clear_obs();
    obs_valid = 0; obs_wrap = 0; obs_err = 0; obs_busy = 0;
  endtask

  // Settle val into the synchroniser, request, then run until the model
  // reports the request finished (bounded).
  task automatic sample(input logic [N-1:0] val, input bit extra_req);
    step(1'b0, val);
    step(1'b0, val);
    step(1'b1, val);
    if (extra_req) step(1'b1, val);
    for (int t = 0; t < 20 && m_busy; t++) step(1'b0, val);
    chk("sample_done", busy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sample_req = 1'b0;
    model_reset();
    #1;
    chk("rst_busy",     busy,     1'b0);
    chk("rst_valid",    valid,    1'b0);
    chk("rst_err",      err,      1'b0);
    chk("rst_wrap",     wrap,     1'b0);
    chk("rst_cnt_out",  cnt_out,  '0);
    chk("rst_wrap_cnt", wrap_cnt, '0);
    @(posedge clk); edge_n++;
    @(posedge clk); edge_n++;
    @(negedge clk);
    reset = 1'b0;
    rel_edge = edge_n;
  endtask

  initial begin
    logic [N-1:0] rv;
    int err_at;
    int bad_vals;
    bit tog;

    reset = 1'b0; sample_req = 1'b0; cnt_in = '0;
    model_reset();
    clear_obs();
    #1 reset = 1'b1;
    #1;
    chk("init_busy",     busy,     1'b0);
    chk("init_valid",    valid,    1'b0);
    chk("init_err",      err,      1'b0);
    chk("init_wrap",     wrap,     1'b0);
    chk("init_cnt_out",  cnt_out,  '0);
    chk("init_wrap_cnt", wrap_cnt, '0);
    @(posedge clk); edge_n++;
    @(posedge clk); edge_n++;
    @(negedge clk);
    reset = 1'b0;
    rel_edge = edge_n;

    // Steady 5: two busy cycles, then valid with 5 and no wrap.
    clear_obs();
    step(1'b0, 4'd5);
    sample(4'd5, 1'b0);
    chk("s1_busy_cycles", obs_busy,  2);
    chk("s1_valid_count", obs_valid, 1);
    chk("s1_cnt_out",     cnt_out,   5);
    chk("s1_wrap_count",  obs_wrap,  0);

    // 14 then 2 is a wrap; 2 again is not.
    sample(4'd14, 1'b0);
    clear_obs();
    sample(4'd2, 1'b0);
    chk("s2_wrap_seen", obs_wrap, 1);
    chk("s2_wrap_cnt",  wrap_cnt, 1);
    clear_obs();
    sample(4'd2, 1'b0);
    chk("s2_nowrap", obs_wrap, 0);

    // Bus toggling every cycle never settles: err 8 edges after the request.
    clear_obs();
    err_at = -1;
    tog = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, tog ? 4'd15 : 4'd0);
      tog = ~tog;
    end
    step(1'b1, tog ? 4'd15 : 4'd0);
    tog = ~tog;
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, tog ? 4'd15 : 4'd0);
      tog = ~tog;
      if (err === 1'b1 && err_at < 0) err_at = i;
    end
    chk("tog_err_at",   err_at,    8);
    chk("tog_no_valid", obs_valid, 0);
    chk("tog_err_once", obs_err,   1);
    chk("tog_keep_cnt", cnt_out,   2);

    // 3 is seen for two compares, then 4 arrives before 3 could be accepted.
    clear_obs();
    bad_vals = 0;
    step(1'b0, 4'd3);
    step(1'b0, 4'd3);
    step(1'b1, 4'd4);
    for (int t = 0; t < 20 && m_busy; t++) begin
      step(1'b0, 4'd4);
      if (valid === 1'b1 && cnt_out !== 4'd4) bad_vals++;
    end
    chk("mid_cnt_out", cnt_out,   4);
    chk("mid_bad",     bad_vals,  0);
    chk("mid_valid",   obs_valid, 1);

    // Reset while COMPARE is in progress, then idle: no stray valid/err.
    step(1'b0, 4'd7);
    step(1'b0, 4'd7);
    step(1'b1, 4'd7);
    step(1'b0, 4'd7);
    chk("pre_rst_busy", busy, 1'b1);
    do_reset();
    clear_obs();
    for (int i = 0; i < 8; i++) step(1'b0, 4'd7);
    chk("post_rst_valid", obs_valid, 0);
    chk("post_rst_err",   obs_err,   0);

    // Random bus activity and requests.
    rv = 4'd0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) rv = N'($urandom);
      step(($urandom_range(2) == 0), rv);
    end

    // Preload 255 wraps, one more rolls wrap_cnt to 0; a request while busy is ignored.
    do_reset();
    for (int i = 0; i < 255; i++) begin
      sample(4'd15, 1'b0);
      sample(4'd0, 1'b0);
    end
    chk("pre_wrap_cnt", wrap_cnt, 255);
    sample(4'd15, 1'b0);
    clear_obs();
    sample(4'd0, 1'b1);
    chk("roll_wrap_seen", obs_wrap,  1);
    chk("roll_wrap_cnt",  wrap_cnt,  0);
    chk("busy_req_once",  obs_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
